// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

  localparam logic [31:0] NOP_BUBBLE       = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] inst;
  } fetch_entry_t;

  // Sequential word address; wraps modulo 2^32.
  function automatic logic [31:0] pc_next(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO holding returned instructions; clear dominates push.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_push,
  input  fetch_entry_t             i_push_entry,
  input  logic                     i_pop,
  input  logic                     i_clear,
  output logic [$clog2(DEPTH):0]   o_count,
  output fetch_entry_t             o_head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  fetch_entry_t        mem [DEPTH];
  logic [AW-1:0]       rd_ptr_q;
  logic [AW-1:0]       wr_ptr_q;
  logic [CW-1:0]       count_q;
  logic                do_pop;
  logic                do_push;

  assign do_pop  = i_pop && (count_q != '0);
  assign do_push = i_push && ((count_q != CW'(DEPTH)) || do_pop);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (i_clear) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset; the head is only observed while count is nonzero.
  always_ff @(posedge i_clk) begin
    if (do_push && !i_clear) begin
      mem[wr_ptr_q] <= i_push_entry;
    end
  end

  assign o_count = count_q;
  assign o_head  = mem[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC generation, imem request/credit control, prefetch queue.
// Optional FETCH_MISALIGN_CHECK_EN adds o_misaligned and traps misaligned redirect targets.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
`ifdef FETCH_MISALIGN_CHECK_EN
  output logic        o_misaligned,
`endif
  output logic        o_valid,
  output logic [31:0] o_pc,
  output logic [31:0] o_inst
);

  localparam int unsigned CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fetch_unit: DEPTH must be a power of 2 and at least 2");
  end

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   deliver_pc_q, deliver_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] q_count;
  fetch_entry_t  q_head;
  fetch_entry_t  push_entry;
  logic          q_valid;
  logic          consume;
  logic          push;
  logic          fire;
  logic [CW:0]   inflight;
  logic [31:0]   redirect_tgt;
  logic          mis_q;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic mis_d;

  assign redirect_tgt = i_redirect_pc;
  assign mis_d        = i_redirect ? (i_redirect_pc[1:0] != 2'b00) : mis_q;
  assign o_misaligned = mis_q;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      mis_q <= 1'b0;
    end else begin
      mis_q <= mis_d;
    end
  end
`else
  logic unused_redirect_lsb;

  assign redirect_tgt        = {i_redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsb = ^i_redirect_pc[1:0];
  assign mis_q               = 1'b0;
`endif

  assign q_valid  = (q_count != '0);
  assign consume  = q_valid && !i_stall && !i_redirect;
  // Credits: every granted request owns a queue slot until it is consumed or dropped.
  assign inflight = {1'b0, outstanding_q} + {1'b0, q_count} - {{CW{1'b0}}, consume};

  assign o_imem_req  = i_reset && !i_redirect && !mis_q && (inflight < DEPTH_W);
  assign o_imem_addr = fetch_pc_q;
  assign fire        = o_imem_req && i_imem_gnt;

  assign push             = i_imem_rvalid && (drop_q == '0) && !mis_q;
  assign push_entry       = '{inst: i_imem_rdata};

  // Next-state for PCs and credit/drop counters; redirect overrides everything.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    deliver_pc_d  = deliver_pc_q;
    drop_d        = drop_q;
    outstanding_d = outstanding_q - CW'(i_imem_rvalid) + CW'(fire);

    if (fire) begin
      fetch_pc_d = pc_next(fetch_pc_q);
    end
    if (consume) begin
      deliver_pc_d = pc_next(deliver_pc_q);
    end
    if (i_imem_rvalid && (drop_q != '0)) begin
      drop_d = drop_q - CW'(1);
    end

    if (i_redirect) begin
      fetch_pc_d   = redirect_tgt;
      deliver_pc_d = redirect_tgt;
      drop_d       = outstanding_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      fetch_pc_q    <= RESET_PC;
      deliver_pc_q  <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      deliver_pc_q  <= deliver_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_push       (push),
    .i_push_entry (push_entry),
    .i_pop        (consume),
    .i_clear      (i_redirect),
    .o_count      (q_count),
    .o_head       (q_head)
  );

  // A trapped misaligned target presents as a held entry with a bubble instruction.
  assign o_valid = q_valid || mis_q;
  assign o_pc    = o_valid ? deliver_pc_q : NOP_BUBBLE;
  assign o_inst  = (q_valid && !mis_q) ? q_head.inst : NOP_BUBBLE;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch front end driving the IF/ID pipeline register: generates sequential PCs, issues word requests to instruction memory over a request/grant + in-order response interface, and buffers returned instructions in a small prefetch queue. It presents one {pc, inst} pair per cycle, holds it under the hazard unit's stall, and discards queued and in-flight instructions on an EX-stage redirect. The IF/ID register consumes `o_pc`/`o_inst`, with `o_valid` low meaning bubble (`o_inst` = 0).

## Interface
- `RESET_PC`, default 32'h0000_0000, first fetch address after reset.
- `DEPTH`, default 2, prefetch queue entries and maximum outstanding requests; power of 2, ≥2.
- `i_clk` in 1: clock.
- `i_reset` in 1: asynchronous, active-low reset.
- `i_stall` in 1: hazard-unit stall, the same signal that holds IF/ID.
- `i_redirect` in 1: branch/jump taken, the same cycle IF/ID is flushed.
- `i_redirect_pc` in 32: redirect target.
- `o_imem_req` out 1: request valid.
- `o_imem_addr` out 32: request word address.
- `i_imem_gnt` in 1: request accepted this cycle.
- `i_imem_rvalid` in 1: response valid; responses return in order, latency ≥1.
- `i_imem_rdata` in 32: response instruction.
- `o_valid` out 1: queue head valid.
- `o_pc` out 32: head PC, 0 when `!o_valid`.
- `o_inst` out 32: head instruction, 0 when `!o_valid`.

## Operation
- Registers: `fetch_pc` (next request address), `deliver_pc` (PC of the queue head), queue count, outstanding count, drop count; all counters are `$clog2(DEPTH)+1` bits.
- Consume condition: `o_valid && !i_stall && !i_redirect`. A consume pops the head and adds 4 to `deliver_pc`.
- Request condition: `o_imem_req = !i_redirect && (outstanding + count − consume < DEPTH)`, with `o_imem_addr = fetch_pc`. Request and address stay stable until granted. A request plus grant adds 4 to `fetch_pc` and increments outstanding.
- Response handling: each `i_imem_rvalid` decrements outstanding.
  - If drop count is nonzero, the response is discarded and drop count decrements.
  - Otherwise it is pushed to the queue. Credit accounting guarantees the queue never overflows.
- Redirect has the highest priority:
  - The queue is cleared.
  - `fetch_pc` and `deliver_pc` are set to `i_redirect_pc`.
  - Drop count is set to outstanding-after-this-cycle: current outstanding minus any same-cycle `i_imem_rvalid`, with the discarded response not counted.
  - No request is issued that cycle.
- Stall: the head is held. Requests continue while credits remain.
- Address width: PC arithmetic is modulo 2^32, and 32'hFFFF_FFFC + 4 wraps to 0.
- Redirect while drop count is nonzero: the new drop count is the total outstanding, covering both stale generations.

## Timing
- Reset values: `o_valid` 0, `o_pc` 0, `o_inst` 0, `o_imem_req` 0, all counters 0, `fetch_pc`/`deliver_pc` = `RESET_PC`.
- First request is in the first cycle after reset deasserts.
- Queue is registered, with no response-to-output bypass. A response in cycle N gives `o_valid` in cycle N+1.
- With 1-cycle memory latency, a redirect in cycle N gives a request in N+1, a response in N+2, and `o_valid` in N+3.
- With `DEPTH`=2 and 1-cycle latency, steady-state throughput is one instruction per cycle.
- Reset mid-operation clears everything immediately. Responses arriving after reset for pre-reset requests are outside the protocol; the memory is reset with the same signal.

## Configuration
- `FETCH_MISALIGN_CHECK_EN` defined:
  - Adds output `o_misaligned` (1 bit, reset 0).
  - A redirect with `i_redirect_pc[1:0] != 0` stops all requests.
  - In-flight responses are still dropped via drop count.
  - After one cycle, the unit presents a single entry: `o_valid`=1, `o_pc`=`i_redirect_pc`, `o_inst`=0, `o_misaligned`=1.
  - That entry is held until the next redirect; consume does not pop it.
- `FETCH_MISALIGN_CHECK_EN` undefined: `i_redirect_pc[1:0]` is forced to 0 and the port is absent.

## Structure
- Shared package `fetch_pkg`: `NOP_BUBBLE` = 32'h0 constant, `RESET_PC` default localparam, and the `fetch_entry_t` struct `{logic [31:0] inst}`.
- One sub-module, `fetch_queue`: a synchronous FIFO parameterized by `DEPTH`, with push, pop, clear, count, and head outputs. Clear has priority over push. All credit and drop logic stays in `fetch_unit`.

## Test plan
- Reset release, 1-cycle memory returning `addr` as data, no stall → requests at 0, 4, 8 on consecutive cycles; `o_valid` from cycle 3, `o_pc`/`o_inst` = 0, 4, 8, one per cycle.
- `i_stall` held 3 cycles with head at pc 8 → `o_pc`=8 held; at most `DEPTH` requests outstanding or queued, and no overflow; sequence resumes 8, C, 10.
- Redirect to 0x100 while 2 responses are in flight → both are dropped; next delivered pair is (0x100, mem[0x100]); no stale PC ever appears with `o_valid`=1.
- Redirect coinciding with `i_imem_rvalid` and a second redirect 1 cycle later to 0x200 → drop count is correct across both; first delivered PC is 0x200.
- Memory with 3-cycle latency and `i_imem_gnt` low for 2 cycles → `o_imem_addr` stable until granted; throughput capped at `DEPTH`/latency; order preserved.
- With `FETCH_MISALIGN_CHECK_EN`: redirect to 0x102 → no further `o_imem_req`; `o_valid`=1, `o_pc`=0x102, `o_inst`=0, `o_misaligned`=1 held; redirect to 0x200 resumes normal fetch.
